// File: rtl/button_pkg.sv
// Shared types and defaults for the LED pulse stretcher: state encoding,
// default timing parameters and the duration-timer width helper.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned ON_CYCLES_DEF  = 25000000;
    localparam int unsigned GAP_CYCLES_DEF = 12500000;
    localparam int unsigned PEND_W_DEF     = 4;

    // Wide enough to hold the larger of the two reload values (N-1), never 0 bits.
    function automatic int unsigned timer_width(input int unsigned on_c, input int unsigned gap_c);
        int unsigned m;
        int unsigned w;
        m = (on_c > gap_c) ? on_c : gap_c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Load-and-count-down duration counter; done is high while the count is 0.
module blink_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    // Holds at zero once expired so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle event strobes into fixed-length LED blinks separated by
// a forced off gap, queueing events that arrive while a blink is in progress.
module led_pulse_stretcher
    import button_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int unsigned PEND_W     = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned TW = timer_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state, state_next;
    logic              load;
    logic [TW-1:0]     load_val;
    logic              done;
    logic              consume;
    logic              has_evt;
    logic [PEND_W-1:0] pending_next;
    logic              overflow_next;

    blink_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (load_val),
        .done  (done)
    );

    assign has_evt = pulse_in || (pending != '0);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        consume    = 1'b0;
        case (state)
            IDLE: if (has_evt) begin
                state_next = ON;
                load       = 1'b1;
                load_val   = ON_LOAD;
                consume    = 1'b1;
            end
            ON: if (done) begin
                state_next = GAP;
                load       = 1'b1;
                load_val   = GAP_LOAD;
            end
            GAP: if (done) begin
                if (has_evt) begin
                    state_next = ON;
                    load       = 1'b1;
                    load_val   = ON_LOAD;
                    consume    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An arrival coinciding with a consume nets out to no change in the queue.
    always_comb begin
        pending_next  = pending;
        overflow_next = overflow;
        if (consume && !pulse_in)
            pending_next = pending - PEND_W'(1);
        else if (!consume && pulse_in) begin
            if (pending == PEND_MAX)
                overflow_next = 1'b1;
            else
                pending_next = pending + PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            led_out  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            led_out  <= (state_next == ON);
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON=4, GAP=2, PEND_W=2.
// Cycle 0 is the first cycle after reset release; outputs are read 1 time unit after each edge.
module tb_led_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_in;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    led_pulse_stretcher #(
        .ON_CYCLES  (4),
        .GAP_CYCLES (2),
        .PEND_W     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .led_out  (led_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pulse_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        pulse_in = 1'b1;
        tick();
        tick();
        checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", led_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        rst      = 1'b0;
        pulse_in = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic el, eb;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            pulse_in = (c == 10);
            el = (c >= 11 && c <= 14);
            eb = (c >= 11 && c <= 16);
            checks++; if (led_out !== el) begin errors++; $display("FAIL single_led cyc=%0d got=%b exp=%b", c, led_out, el); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, eb); end
            checks++; if (pending !== 2'd0) begin errors++; $display("FAIL single_pending cyc=%0d got=%0d exp=0", c, pending); end
            tick();
        end
        pulse_in = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic el, eb;
        logic [1:0] ep;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            pulse_in = (c >= 10 && c <= 12);
            el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26);
            eb = (c >= 11 && c <= 28);
            if (c == 12)                 ep = 2'd1;
            else if (c >= 13 && c <= 16) ep = 2'd2;
            else if (c >= 17 && c <= 22) ep = 2'd1;
            else                         ep = 2'd0;
            checks++; if (led_out !== el) begin errors++; $display("FAIL b2b_led cyc=%0d got=%b exp=%b", c, led_out, el); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", c, busy, eb); end
            checks++; if (pending !== ep) begin errors++; $display("FAIL b2b_pending cyc=%0d got=%0d exp=%0d", c, pending, ep); end
            tick();
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_saturation();
        logic el, eo, prev;
        logic [1:0] ep;
        int blinks;
        blinks = 0;
        prev   = 1'b0;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            pulse_in = (c >= 10 && c <= 15);
            el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26) || (c >= 29 && c <= 32);
            eo = (c >= 15);
            if (c <= 11)                 ep = 2'd0;
            else if (c == 12)            ep = 2'd1;
            else if (c == 13)            ep = 2'd2;
            else if (c >= 14 && c <= 16) ep = 2'd3;
            else if (c >= 17 && c <= 22) ep = 2'd2;
            else if (c >= 23 && c <= 28) ep = 2'd1;
            else                         ep = 2'd0;
            if (led_out === 1'b1 && prev === 1'b0) blinks++;
            prev = led_out;
            checks++; if (led_out !== el) begin errors++; $display("FAIL sat_led cyc=%0d got=%b exp=%b", c, led_out, el); end
            checks++; if (overflow !== eo) begin errors++; $display("FAIL sat_overflow cyc=%0d got=%b exp=%b", c, overflow, eo); end
            checks++; if (pending !== ep) begin errors++; $display("FAIL sat_pending cyc=%0d got=%0d exp=%0d", c, pending, ep); end
            tick();
        end
        pulse_in = 1'b0;
        checks++; if (blinks != 4) begin errors++; $display("FAIL sat_blinks got=%0d exp=4", blinks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_idle got=%b exp=0", busy); end
    endtask

    task automatic test_gap_boundary();
        logic el, eb;
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            pulse_in = (c == 10) || (c == 16);
            el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20);
            eb = (c >= 11 && c <= 22);
            checks++; if (led_out !== el) begin errors++; $display("FAIL gap_led cyc=%0d got=%b exp=%b", c, led_out, el); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL gap_busy cyc=%0d got=%b exp=%b", c, busy, eb); end
            checks++; if (pending !== 2'd0) begin errors++; $display("FAIL gap_pending cyc=%0d got=%0d exp=0", c, pending); end
            tick();
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_reset_mid_on();
        logic el, eb;
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            pulse_in = (c >= 10 && c <= 13);
            tick();
        end
        // cycle 18: second ON cycle of the second blink, two events still queued
        checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL mid_led_pre got=%b exp=1", led_out); end
        checks++; if (pending !== 2'd2) begin errors++; $display("FAIL mid_pending_pre got=%0d exp=2", pending); end
        rst      = 1'b1;
        pulse_in = 1'b1;
        tick();
        rst      = 1'b0;
        pulse_in = 1'b0;
        checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL mid_led got=%b exp=0", led_out); end
        checks++; if (pending !== 2'd0) begin errors++; $display("FAIL mid_pending got=%0d exp=0", pending); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
        // replay single-event timing relative to the reset release
        for (int c = 0; c <= 20; c++) begin
            pulse_in = (c == 10);
            el = (c >= 11 && c <= 14);
            eb = (c >= 11 && c <= 16);
            checks++; if (led_out !== el) begin errors++; $display("FAIL mid_replay_led cyc=%0d got=%b exp=%b", c, led_out, el); end
            checks++; if (busy !== eb) begin errors++; $display("FAIL mid_replay_busy cyc=%0d got=%b exp=%b", c, busy, eb); end
            checks++; if (pending !== 2'd0) begin errors++; $display("FAIL mid_replay_pending cyc=%0d got=%0d exp=0", c, pending); end
            tick();
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_gap_boundary();
        test_reset_mid_on();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
